// File: rtl/riscv_instr_issuer.sv
// riscv_instr_issuer: buffers a program and replays it one word per clock into the core.
// Define ISSUER_HAZARD_EN to insert NOP bubbles on RAW hazards; otherwise words issue back-to-back.
module riscv_instr_issuer #(
  parameter int DEPTH        = 64,
  parameter int HAZARD_DIST  = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  input  logic          start,
  output logic [31:0]   in_instr,
  output logic          issue_valid,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DW  = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic [31:0]   mem [DEPTH];
  logic [AW:0]   count, count_n;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] drain_cnt;
  logic [31:0]   cur;
  logic          accept, hazard, last;

  assign cur        = mem[rd_ptr];
  assign load_ready = (state == IDLE) && (count < (AW+1)'(DEPTH));
  assign accept     = load_ready && load_valid;
  assign count_n    = clear ? '0 : count + (AW+1)'(accept);
  assign last       = ({1'b0, rd_ptr} == count - (AW+1)'(1));
  assign busy       = (state != IDLE);

`ifdef ISSUER_HAZARD_EN
  // hist[0] is the rd of the most recent issue slot; bubbles record x0
  logic [HAZARD_DIST-1:0][4:0] hist;
  logic use1, use2, wr;

  always_comb begin
    use1   = 1'b0;
    use2   = 1'b0;
    wr     = 1'b0;
    hazard = 1'b0;
    case (cur[6:0])
      7'b0110011:                         begin use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
      7'b1100011, 7'b0100011:             begin use1 = 1'b1; use2 = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin use1 = 1'b1; wr = 1'b1; end
      7'b0110111, 7'b0010111, 7'b1101111: wr = 1'b1;
      default: ;
    endcase
    for (int i = 0; i < HAZARD_DIST; i++)
      if (hist[i] != 5'd0 && ((use1 && hist[i] == cur[19:15]) || (use2 && hist[i] == cur[24:20])))
        hazard = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else if (state == IDLE) hist <= '0;
    else if (state == RUN) begin
      hist[0] <= (!hazard && wr) ? cur[11:7] : 5'd0;
      for (int i = 1; i < HAZARD_DIST; i++) hist[i] <= hist[i-1];
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && count_n != '0) state_n = RUN;
      RUN:     if (!hazard && last) state_n = DRAIN;
      DRAIN:   if (drain_cnt == DW'(DRAIN_CYCLES)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Buffer storage is not reset; count alone defines valid contents.
  always_ff @(posedge clk) begin
    if (accept) mem[count[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_instr    <= NOP;
      issue_valid <= 1'b0;
      pc_out      <= '0;
      done        <= 1'b0;
      stall_cnt   <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      drain_cnt   <= '0;
    end else begin
      in_instr    <= NOP;
      issue_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          count     <= count_n;
          drain_cnt <= '0;
          if (state_n == RUN) begin
            rd_ptr    <= '0;
            stall_cnt <= '0;
          end
        end
        RUN: begin
          if (hazard) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          end else begin
            in_instr    <= cur;
            issue_valid <= 1'b1;
            pc_out      <= rd_ptr;
            rd_ptr      <= rd_ptr + AW'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (state_n == IDLE) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_instr_issuer.sv
// tb_riscv_instr_issuer: scoreboard bench; expected issue slots are built from the loaded program
// with a last-write-slot hazard model, then popped and compared slot by slot.
module tb_riscv_instr_issuer;
  localparam int DEPTH = 64, HD = 2, DRN = 4, AW = 6;
`ifdef ISSUER_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0, rst, clear, load_valid, start;
  logic [31:0]   load_data, in_instr;
  logic          load_ready, issue_valid, busy, done;
  logic [AW-1:0] pc_out;
  logic [15:0]   stall_cnt;

  int          n_cmp = 0, n_err = 0, exp_stall;
  logic [31:0] prog[$];
  logic [39:0] sb[$];  // {busy, issue_valid, pc, instr}

  always #5 clk = ~clk;

  riscv_instr_issuer #(.DEPTH(DEPTH), .HAZARD_DIST(HD), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .in_instr(in_instr), .issue_valid(issue_valid),
    .pc_out(pc_out), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit wr_rd(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic bit use_rs1(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h63, 7'h23, 7'h13, 7'h03, 7'h67: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic bit use_rs2(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h63, 7'h23: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // A register written at slot t is readable from slot t+HD+1 onward.
  task automatic build();
    int lastw[32];
    int t = 0;
    logic [31:0] w;
    bit h;
    foreach (lastw[r]) lastw[r] = -100;
    sb.delete();
    exp_stall = 0;
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      forever begin
        h = (use_rs1(w) && w[19:15] != 0 && t - lastw[w[19:15]] <= HD) ||
            (use_rs2(w) && w[24:20] != 0 && t - lastw[w[24:20]] <= HD);
        if (!(HZ && h)) break;
        sb.push_back({1'b1, 1'b0, 6'd0, NOP});
        exp_stall++;
        t++;
      end
      sb.push_back({1'b1, 1'b1, 6'(i), w});
      if (wr_rd(w) && w[11:7] != 0) lastw[w[11:7]] = t;
      t++;
    end
    repeat (DRN) sb.push_back({1'b1, 1'b0, 6'd0, NOP});
  endtask

  task automatic load(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) load(prog[i]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // ld_last: the final program word is loaded in the same cycle as start
  task automatic run_check(input string tag, input bit ld_last);
    logic [39:0] e;
    int nv = 0, k = 0;
    build();
    start = 1'b1;
    if (ld_last) begin
      load_valid = 1'b1;
      load_data  = prog[prog.size()-1];
    end
    @(posedge clk); #1;
    start = 1'b0;
    load_valid = 1'b0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("%s.slot%0d", tag, k), {busy, issue_valid, issue_valid ? pc_out : 6'd0, in_instr}, e);
      if (issue_valid) nv++;
      k++;
    end
    @(posedge clk); #1;
    chk({tag, ".done"}, {busy, done}, 2'b01);
    chk({tag, ".stall"}, stall_cnt, exp_stall);
    chk({tag, ".nvalid"}, nv, prog.size());
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; load_valid = 1'b0; start = 1'b0; load_data = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset", {in_instr, issue_valid, pc_out, busy, done, load_ready, stall_cnt},
        {NOP, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 16'd0});
    rst = 1'b0;
    @(posedge clk); #1;

    prog = '{32'h00500293, 32'h00128333};
    load_prog(2);
    run_check("raw", 1'b0);
    chk("raw.stall_cnt", stall_cnt, HZ ? 16'd2 : 16'd0);

    do_clear();
    prog = '{32'hFFFFF7B7, 32'h00100093};
    load_prog(2);
    run_check("indep", 1'b0);

    do_clear();
    prog = '{32'h00000033, 32'h00000133};
    load_prog(2);
    run_check("x0prod", 1'b0);

    do_clear();
    prog = '{32'h0000A183, 32'h00100393, 32'h00312023, 32'h00338063};
    load_prog(4);
    run_check("ldst", 1'b0);
    run_check("replay", 1'b0);

    do_clear();
    prog = '{32'h00500293, 32'h00128333};
    load_prog(1);
    run_check("ld_start", 1'b1);

    do_clear();
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    load_prog(DEPTH);
    chk("full.load_ready", load_ready, 1'b0);
    load(32'hDEADBEEF);
    run_check("full", 1'b0);

    // clear beats a same-cycle load, so the following start is ignored
    clear = 1'b1;
    load_valid = 1'b1;
    load_data = 32'h00100093;
    @(posedge clk); #1;
    clear = 1'b0;
    load_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("clear_wins.busy", busy, 1'b0);

    prog = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};
    load_prog(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrun.busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun.rst", {in_instr, issue_valid, pc_out, busy, done, load_ready, stall_cnt},
        {NOP, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 16'd0});
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("empty_start", {busy, issue_valid, in_instr}, {1'b0, 1'b0, NOP});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_instr_issuer.md
# riscv_instr_issuer

Hazard-aware instruction issuer that drives the RISC_V core's 32-bit instruction input. A program is loaded word-by-word into an internal buffer, then replayed one instruction per clock on `start`. Bubbles (canonical NOP) are inserted wherever a read-after-write dependency falls inside the core's unforwarded window, so hazard-prone sequences execute correctly without hand-padding. A fixed NOP drain follows the last instruction.

## Interface
- `DEPTH`, 64, program buffer entries (power of 2); `AW = $clog2(DEPTH)`
- `HAZARD_DIST`, 2, issue slots after a producer during which its `rd` is unreadable (1..4)
- `DRAIN_CYCLES`, 4, NOPs issued after the last instruction
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `clear`  in  1  empties program buffer (IDLE only; ignored otherwise)
- `load_valid`  in  1  load word present
- `load_data`  in  32  instruction word to append
- `load_ready`  out  1  buffer accepts a word this cycle
- `start`  in  1  begin replay (IDLE only)
- `in_instr`  out  32  instruction to core `in` port, registered
- `issue_valid`  out  1  `in_instr` is a program instruction (0 for bubble/drain/idle NOP)
- `pc_out`  out  AW  buffer index of the word on `in_instr` when `issue_valid`
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse on DRAIN→IDLE
- `stall_cnt`  out  16  bubbles inserted in current/last run, saturating

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `load_ready = (count < DEPTH)`; accepted word written at `buf[count]`, `count++`. `clear` sets `count=0` (wins over a same-cycle load). `start` with `count>0` → RUN, `rd_ptr=0`, `stall_cnt=0`, hazard history cleared; `start` with `count==0` ignored. Load and `start` in the same cycle: word accepted, then RUN includes it.
- RUN: each cycle, examine `buf[rd_ptr]`.
  - Source use by opcode: 0110011/1100011/0100011 → rs1,rs2; 0010011/0000011/1100111 → rs1; 0110111/0010111/1101111 → none; other opcodes → none.
  - Destination: 0110011/0010011/0000011/0110111/0010111/1101111/1100111 write `rd`; others write nothing. `rd==x0` never creates a hazard.
  - Hazard = any used source equals a nonzero `rd` recorded in the last `HAZARD_DIST` issue slots.
  - Hazard: issue NOP 0x00000013, `issue_valid=0`, `stall_cnt++` (sat 0xFFFF), history shifts in x0.
  - No hazard: issue word, `issue_valid=1`, `pc_out=rd_ptr`, history shifts in its `rd`, `rd_ptr++`.
  - Issuing index `count-1` → DRAIN.
- DRAIN: issue `DRAIN_CYCLES` NOPs, then → IDLE with `done` pulse. Buffer contents and `count` retained; `start` replays.
- `load_valid` outside IDLE: `load_ready=0`, data dropped. `load_ready` does not depend combinationally on `load_valid`.

## Timing
- Reset values: `in_instr=0x00000013`, `issue_valid=0`, `pc_out=0`, `busy=0`, `done=0`, `load_ready=1`, `stall_cnt=0`, `count=0`, state IDLE.
- `start` sampled at edge N; first instruction/bubble on `in_instr` after edge N+1.
- One issue slot per clock; no backpressure from core.
- Run length = `count + stall_cnt` slots, then `DRAIN_CYCLES` NOP slots; `done` asserted in the cycle after the last drain slot.
- `rst` mid-run: immediate abort to reset values; buffer count lost.

## Configuration
- `ISSUER_HAZARD_EN` defined: interlock as above.
- Not defined: hazard check removed; every RUN slot issues the next word back-to-back, `stall_cnt` stays 0. Used to reproduce raw core hazard behaviour.

## Test plan
- Load 0x00500293 (addi x5,x0,5), 0x00128333 (add x6,x5,x1), `start`, HAZARD_DIST=2 → `in_instr` sequence 0x00500293, 0x00000013, 0x00000013, 0x00128333, then 4 NOPs; `stall_cnt=2`, `issue_valid` 1,0,0,1; `done` one pulse.
- Load 0xFFFFF7B7 (lui x15), 0x00100093 (addi x1,x0,1) → issued back-to-back, `stall_cnt=0`, `pc_out` 0,1.
- Load 0x00000033 (add x0,x0,x0) then 0x00000133 (add x2,x0,x0) → no bubble (x0 producer ignored).
- Fill 64 words → `load_ready=0` after 64th accept; 65th word dropped; replay issues exactly 64 `issue_valid` slots.
- Assert `rst` during RUN slot 3 → all outputs at reset values next cycle; `start` with empty buffer ignored.
- Without `ISSUER_HAZARD_EN`, first scenario → 0x00500293, 0x00128333 adjacent, `stall_cnt=0`.
